// File: rtl/serial_pkg.sv
// Shared definitions for the serial datapath blocks: FSM state encoding
// and a ceiling-log2 helper used to size bit counters.
package serial_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Ceiling log2, never below 1 so a counter always has at least one bit.
  function automatic int clog2(input int value);
    int r;
    int x;
    r = 0;
    x = value - 1;
    while (x > 0) begin
      r++;
      x = x >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/piso_serializer_if.sv
// Producer-facing handshake plus serial-line outputs of the serializer.
// master: the producer / line driver side; slave: the serializer itself.
interface piso_serializer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] data_in;
  logic             in_valid;
  logic             in_ready;
  logic             bit_en;
  logic             data_out;
  logic             out_valid;
  logic             frame_start;
  logic             frame_last;
  logic             busy;

  modport master (
    output data_in, in_valid, bit_en,
    input  in_ready, data_out, out_valid, frame_start, frame_last, busy
  );

  modport slave (
    input  data_in, in_valid, bit_en,
    output in_ready, data_out, out_valid, frame_start, frame_last, busy
  );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in / serial-out serializer. A one-word holding register sits in
// front of the shift register so the next frame starts on the strobe right
// after the last bit of the current one, with no idle bit between frames.
module piso_serializer
  import serial_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  piso_serializer_if.slave bus
);

  localparam int                CNT_W    = clog2(WIDTH);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   hold_q, hold_d;
  logic               hold_full_q, hold_full_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               dout_q, dout_d;
  logic               oval_q, oval_d;
  logic               fstart_q, fstart_d;
  logic               flast_q, flast_d;
  logic               load;
  logic [WIDTH-1:0]   shifted;

  // The bit that leaves the word first (and, after each shift, next).
  function automatic logic exit_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  // Move the word one position towards its exit end, filling with 0.
  function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  // Next-state: handshake into the holding register, frame loading and shifting.
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shreg_d     = shreg_q;
    cnt_d       = cnt_q;
    dout_d      = dout_q;
    oval_d      = oval_q;
    fstart_d    = fstart_q;
    flast_d     = flast_q;
    load        = 1'b0;
    shifted     = shift_word(shreg_q);

    // Accept only into an empty holding register; a load needs it full,
    // so accept and load can never happen on the same edge.
    if (bus.in_valid && !hold_full_q) begin
      hold_d      = bus.data_in;
      hold_full_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (bus.bit_en && hold_full_q) load = 1'b1;
      end
      SHIFT: begin
        if (bus.bit_en) begin
          if (cnt_q != LAST_CNT) begin
            shreg_d  = shifted;
            dout_d   = exit_bit(shifted);
            cnt_d    = cnt_q + CNT_ONE;
            fstart_d = 1'b0;
            flast_d  = ((cnt_q + CNT_ONE) == LAST_CNT);
          end else if (hold_full_q) begin
            load = 1'b1;
          end else begin
            dout_d   = IDLE_LEVEL;
            oval_d   = 1'b0;
            fstart_d = 1'b0;
            flast_d  = 1'b0;
            state_d  = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      shreg_d     = hold_q;
      hold_full_d = 1'b0;
      dout_d      = exit_bit(hold_q);
      oval_d      = 1'b1;
      fstart_d    = 1'b1;
      flast_d     = 1'b0;
      cnt_d       = '0;
      state_d     = SHIFT;
    end
  end

  // State and output registers; reset aborts any frame and drops the held word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shreg_q     <= '0;
      cnt_q       <= '0;
      dout_q      <= IDLE_LEVEL;
      oval_q      <= 1'b0;
      fstart_q    <= 1'b0;
      flast_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      dout_q      <= dout_d;
      oval_q      <= oval_d;
      fstart_q    <= fstart_d;
      flast_q     <= flast_d;
    end
  end

  assign bus.in_ready    = !hold_full_q;
  assign bus.data_out    = dout_q;
  assign bus.out_valid   = oval_q;
  assign bus.frame_start = fstart_q;
  assign bus.frame_last  = flast_q;
  assign bus.busy        = oval_q | hold_full_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: an MSB-first and an LSB-first instance share
// one stimulus stream; a queue of expected frame bits is compared on every
// bit_en strobe, and outputs must hold between strobes.
module tb_piso_serializer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         vld;
  logic         ben;
  logic [W-1:0] din;
  int           ben_mode;
  int           n_chk = 0;
  int           n_fail = 0;

  always #5 clk = ~clk;

  piso_serializer_if #(.WIDTH(W)) ifm ();
  piso_serializer_if #(.WIDTH(W)) ifl ();

  assign ifm.data_in  = din;
  assign ifm.in_valid = vld;
  assign ifm.bit_en   = ben;
  assign ifl.data_in  = din;
  assign ifl.in_valid = vld;
  assign ifl.bit_en   = ben;

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut_m (
    .clk(clk), .reset(rst), .bus(ifm)
  );
  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut_l (
    .clk(clk), .reset(rst), .bus(ifl)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected serial bits: one entry per frame bit, for both bit orders.
  typedef struct {
    logic bm;
    logic bl;
    int   idx;
  } exp_t;

  exp_t q[$];
  int   rem = 0;
  logic disp = 1'b0;

  // bit_en generator: 0 every cycle, 1 every 4th cycle, 2 random, other off.
  initial begin
    int c;
    c = 0;
    ben = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      c++;
      case (ben_mode)
        0:       ben = 1'b1;
        1:       ben = ((c % 4) == 0);
        2:       ben = ($urandom_range(0, 1) == 1);
        default: ben = 1'b0;
      endcase
    end
  end

  // Monitor / scoreboard.
  initial begin
    logic         e_ben, e_acc, e_rst, hf, have_prev;
    logic [W-1:0] e_d;
    logic [7:0]   now, prev;
    exp_t         e;
    have_prev = 1'b0;
    prev = '0;
    forever begin
      @(posedge clk);
      e_ben = ben;
      e_acc = vld & ifm.in_ready;
      e_d   = din;
      e_rst = rst;
      #2;
      if (e_rst || rst) begin
        q.delete();
        rem = 0;
        disp = 1'b0;
        have_prev = 1'b0;
      end else begin
        now = {ifm.data_out, ifm.out_valid, ifm.frame_start, ifm.frame_last,
               ifl.data_out, ifl.out_valid, ifl.frame_start, ifl.frame_last};
        if (e_ben) begin
          if (q.size() > 0) begin
            e = q.pop_front();
            chk("bit", now, {e.bm, 1'b1, (e.idx == 0), (e.idx == W - 1),
                             e.bl, 1'b1, (e.idx == 0), (e.idx == W - 1)});
            rem  = W - 1 - e.idx;
            disp = 1'b1;
          end else begin
            chk("idle_line", now, 8'h00);
            rem  = 0;
            disp = 1'b0;
          end
        end else if (have_prev) begin
          chk("hold_between_strobes", now, prev);
        end
        prev = now;
        have_prev = 1'b1;
        if (e_acc) begin
          for (int i = 0; i < W; i++)
            q.push_back('{bm: e_d[W-1-i], bl: e_d[i], idx: i});
        end
        // A word is waiting in the holding register iff more bits are
        // queued than remain of the frame currently on the line.
        hf = (q.size() > rem);
        chk("ready_busy", {ifm.in_ready, ifl.in_ready, ifm.busy, ifl.busy},
            {!hf, !hf, (disp | hf), (disp | hf)});
      end
    end
  end

  task automatic send(input logic [W-1:0] w);
    int  t;
    logic done;
    t = 0;
    done = 1'b0;
    din = w;
    vld = 1'b1;
    while (!done) begin
      @(posedge clk);
      if (ifm.in_ready) begin
        done = 1'b1;
      end else begin
        t++;
        if (t > 500) begin
          n_chk++;
          n_fail++;
          $display("FAIL send_timeout: word %0h not accepted", w);
          done = 1'b1;
        end
      end
    end
    #1;
    vld = 1'b0;
  endtask

  task automatic wait_idle();
    int  t;
    logic done;
    t = 0;
    done = 1'b0;
    while (!done) begin
      @(posedge clk);
      #3;
      if (!ifm.busy && !ifl.busy && q.size() == 0) begin
        done = 1'b1;
      end else begin
        t++;
        if (t > 500) begin
          n_chk++;
          n_fail++;
          $display("FAIL drain_timeout: busy %0b queue %0d", ifm.busy, q.size());
          done = 1'b1;
        end
      end
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk(nm, {ifm.data_out, ifm.out_valid, ifm.frame_start, ifm.frame_last, ifm.busy, ifm.in_ready,
             ifl.data_out, ifl.out_valid, ifl.frame_start, ifl.frame_last, ifl.busy, ifl.in_ready},
        12'b000001_000001);
  endtask

  initial begin
    rst = 1'b1;
    vld = 1'b0;
    din = '0;
    ben_mode = 3;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset_state");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single frame, strobe every cycle (both bit orders).
    ben_mode = 0;
    send(8'hC1);
    wait_idle();

    // Three words queued back to back: must stream without a gap.
    send(8'hF0);
    send(8'h0F);
    send(8'hAA);
    wait_idle();

    // Strobe every 4th cycle.
    ben_mode = 1;
    send(8'h81);
    wait_idle();

    // Accepted while no strobe: held, not yet on the line.
    ben_mode = 3;
    repeat (2) @(posedge clk);
    #1;
    send(8'h55);
    chk("held_no_strobe", {ifm.in_ready, ifm.busy, ifm.out_valid}, 3'b010);
    repeat (4) @(posedge clk);
    #1;
    chk("still_waiting", {ifm.out_valid, ifl.out_valid}, 2'b00);
    ben_mode = 0;
    wait_idle();

    // Reset mid-frame with a second word held.
    send(8'hFF);
    send(8'h3C);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_reset_outputs("async_reset_midframe");
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk("after_reset_quiet", {ifm.out_valid, ifl.out_valid, ifm.in_ready, ifm.busy}, 4'b0010);

    // Randomized traffic with mixed strobe patterns.
    for (int n = 0; n < 40; n++) begin
      ben_mode = $urandom_range(0, 2);
      send(W'($urandom));
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
    end
    ben_mode = 0;
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
